// File: rtl/gol_pkg.sv
// Shared definitions for the gol grid and its reader-side streamer.
//   GOL_ROWS/GOL_COLS : default grid size used by gol, the streamer and benches
//   stream_state_t    : streamer FSM state
//   idx_w(n)          : index width for n entries, never less than 1 bit
package gol_pkg;

  localparam int GOL_ROWS = 3;
  localparam int GOL_COLS = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gol_cell_cursor.sv
// Row-major cell cursor for the grid streamer.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   load_zero   : force the cursor to (0,0)
//   advance     : step to the next cell; wraps from (ROWS-1,COLS-1) to (0,0)
//   row, col    : current cursor position
//   at_sol      : col == 0
//   at_eol      : col == COLS-1
//   at_eof      : row == ROWS-1 and col == COLS-1
module gol_cell_cursor
  import gol_pkg::*;
#(
  parameter int ROWS = GOL_ROWS,
  parameter int COLS = GOL_COLS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_zero,
  input  logic                     advance,
  output logic [idx_w(ROWS)-1:0]   row,
  output logic [idx_w(COLS)-1:0]   col,
  output logic                     at_sol,
  output logic                     at_eol,
  output logic                     at_eof
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign at_sol = (col_q == '0);
  assign at_eol = (col_q == LAST_COL);
  assign at_eof = at_eol && (row_q == LAST_ROW);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (load_zero) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (at_eol) begin
        col_d = '0;
        row_d = at_eof ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/gol_grid_streamer.sv
// Snapshots the parallel gol grid on request and streams it out one cell per
// handshake in row-major order, with row/col indices and framing markers.
// Ports:
//   clk, rst_n             : clock and synchronous active-low reset
//   grid_in[r][c]          : live grid from gol
//   snap                   : capture request, sampled every edge
//   busy                   : a frame is held or streaming
//   cell_valid/cell_ready  : output handshake
//   cell_data/row/col      : current cell value and position
//   sol/eol/eof            : first-of-row, last-of-row, last-of-frame markers
//   frame_count            : completed frames (wraps)
//   drop_count             : snap requests ignored while streaming (saturates)
//   state_dbg              : current FSM state for observation
//
// Handshake: a cell transfers on every rising edge where cell_valid and
// cell_ready are both 1. Once cell_valid is high it stays high, and every
// cell_* output and marker holds stable, until that cell transfers; only
// reset may withdraw it.
module gol_grid_streamer
  import gol_pkg::*;
#(
  parameter int ROWS  = GOL_ROWS,
  parameter int COLS  = GOL_COLS,
  parameter int CNT_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ROWS-1:0][COLS-1:0]        grid_in,
  input  logic                             snap,
  output logic                             busy,
  output logic                             cell_valid,
  input  logic                             cell_ready,
  output logic                             cell_data,
  output logic [idx_w(ROWS)-1:0]           cell_row,
  output logic [idx_w(COLS)-1:0]           cell_col,
  output logic                             sol,
  output logic                             eol,
  output logic                             eof,
  output logic [CNT_W-1:0]                 frame_count,
  output logic [CNT_W-1:0]                 drop_count,
  output stream_state_t                    state_dbg
);

  stream_state_t                 state_q;
  logic [ROWS-1:0][COLS-1:0]     snapshot_q;
  logic                          valid_q;
  logic                          busy_q;
  logic [CNT_W-1:0]              frame_count_q;
  logic [CNT_W-1:0]              drop_count_q;

  logic at_sol, at_eol, at_eof;
  logic transfer;
  logic cur_load;

  assign transfer = valid_q && cell_ready;
  // The cursor wraps to (0,0) on its own after the eof transfer, so it only
  // needs an explicit clear when a frame starts from IDLE.
  assign cur_load = (state_q == IDLE) && snap;

  gol_cell_cursor #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_cursor (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (cur_load),
    .advance   (transfer),
    .row       (cell_row),
    .col       (cell_col),
    .at_sol    (at_sol),
    .at_eol    (at_eol),
    .at_eof    (at_eof)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      snapshot_q    <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snap) begin
            snapshot_q <= grid_in;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (transfer && at_eof) begin
            frame_count_q <= frame_count_q + 1'b1;
            if (snap) begin
              // Back-to-back frame: recapture and keep valid high.
              snapshot_q <= grid_in;
            end else begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (snap) begin
            if (drop_count_q != '1) begin
              drop_count_q <= drop_count_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cell_valid  = valid_q;
  assign busy        = busy_q;
  assign cell_data   = snapshot_q[cell_row][cell_col];
  assign sol         = valid_q && at_sol;
  assign eol         = valid_q && at_eol;
  assign eof         = valid_q && at_eof;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_gol_grid_streamer.sv
module tb_gol_grid_streamer;
  import gol_pkg::*;

  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int CNT_W = 8;
  localparam int NC    = ROWS * COLS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic [ROWS-1:0][COLS-1:0] grid_in;
  logic                      snap;
  logic                      busy;
  logic                      cell_valid;
  logic                      cell_ready;
  logic                      cell_data;
  logic [1:0]                cell_row;
  logic [1:0]                cell_col;
  logic                      sol, eol, eof;
  logic [CNT_W-1:0]          frame_count;
  logic [CNT_W-1:0]          drop_count;
  stream_state_t             state_dbg;

  gol_grid_streamer #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .grid_in     (grid_in),
    .snap        (snap),
    .busy        (busy),
    .cell_valid  (cell_valid),
    .cell_ready  (cell_ready),
    .cell_data   (cell_data),
    .cell_row    (cell_row),
    .cell_col    (cell_col),
    .sol         (sol),
    .eol         (eol),
    .eof         (eof),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {data, row[1:0], col[1:0], sol, eol, eof}
  localparam int W = 8;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int valid_cycles = 0;
  int cell_idx = 0;

  // Hand-chosen grids; flat bit r*COLS+c is the cell at (r,c), i.e. cell k.
  localparam logic [NC-1:0] G_VBLINK = 9'b010_010_010; // cells 1,4,7
  localparam logic [NC-1:0] G_HBLINK = 9'b000_111_000; // cells 3,4,5
  localparam logic [NC-1:0] G_CHECK  = 9'b101_010_101;
  localparam logic [NC-1:0] G_DIAG   = 9'b100_010_001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected stream for one frame: row-major, markers from position.
  task automatic push_frame(input logic [NC-1:0] g);
    for (int k = 0; k < NC; k++) begin
      logic [1:0] r, c;
      r = 2'(k / COLS);
      c = 2'(k % COLS);
      exp_q.push_back({g[k], r, c, (c == 2'd0), (c == 2'(COLS - 1)),
                       (k == NC - 1)});
    end
  endtask

  // Monitor: every valid cycle is compared against the queue head (so a
  // stalled cell is rechecked each cycle); the head is popped on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cell_valid) begin
        valid_cycles++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_cell: got %0h expected none",
                   {cell_data, cell_row, cell_col, sol, eol, eof});
        end else begin
          if ({cell_data, cell_row, cell_col, sol, eol, eof} !== exp_q[0]) begin
            n_err++;
            $display("FAIL cell[%0d]: got %0h expected %0h", cell_idx,
                     {cell_data, cell_row, cell_col, sol, eol, eof}, exp_q[0]);
          end
          if (cell_ready) begin
            void'(exp_q.pop_front());
            cell_idx++;
          end
        end
      end else if (sol || eol || eof) begin
        n_vec++;
        n_err++;
        $display("FAIL markers_idle: got %0b%0b%0b expected 000", sol, eol, eof);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    snap  = 1'b0;
    cell_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    cell_idx = 0;
    check("rst_busy",  busy, 0);
    check("rst_valid", cell_valid, 0);
    check("rst_pos",   {cell_data, cell_row, cell_col, sol, eol, eof}, 0);
    check("rst_frames", frame_count, 0);
    check("rst_drops",  drop_count, 0);
    check("rst_state",  state_dbg, IDLE);
  endtask

  // Pulse snap for one edge with grid g; returns #1 after the sampling edge.
  task automatic start_frame(input logic [NC-1:0] g);
    valid_cycles = 0;
    grid_in = g;
    snap = 1'b1;
    push_frame(g);
    @(posedge clk);
    #1;
    snap = 1'b0;
    check("start_valid", cell_valid, 1);
    check("start_busy",  busy, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (cell_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cell_valid) check({name, "_timeout"}, 1, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    grid_in = '0;
    snap = 1'b0;
    cell_ready = 1'b0;
    rst_n = 1'b0;

    // Blinker frame, continuous ready.
    do_reset();
    cell_ready = 1'b1;
    start_frame(G_VBLINK);
    wait_idle("blink");
    check("blink_cycles", valid_cycles, 9);
    check("blink_busy",   busy, 0);
    check("blink_frames", frame_count, 1);

    // Backpressure: stall 3 cycles while cell 4 is presented.
    do_reset();
    cell_ready = 1'b1;
    start_frame(G_VBLINK);
    repeat (4) @(posedge clk);
    #1;
    cell_ready = 1'b0;
    check("bp_row",  cell_row, 1);
    check("bp_col",  cell_col, 1);
    check("bp_data", cell_data, 1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_held_col", cell_col, 1);
    cell_ready = 1'b1;
    wait_idle("bp");
    check("bp_cycles", valid_cycles, 12);
    check("bp_frames", frame_count, 1);

    // Back-to-back: snap on the eof handshake edge.
    do_reset();
    cell_ready = 1'b1;
    start_frame(G_VBLINK);
    repeat (8) @(posedge clk);
    #1;
    check("b2b_eof", eof, 1);
    grid_in = G_HBLINK;
    snap = 1'b1;
    push_frame(G_HBLINK);
    @(posedge clk);
    #1;
    snap = 1'b0;
    check("b2b_nobubble", cell_valid, 1);
    wait_idle("b2b");
    check("b2b_cycles", valid_cycles, 18);
    check("b2b_frames", frame_count, 2);
    check("b2b_drops",  drop_count, 0);

    // Drops: two mid-stream snap pulses, grid changed meanwhile.
    do_reset();
    cell_ready = 1'b1;
    start_frame(G_CHECK);
    @(posedge clk);
    #1;
    grid_in = '1;
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    @(posedge clk);
    #1;
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    wait_idle("drop");
    check("drop_count",  drop_count, 2);
    check("drop_frames", frame_count, 1);
    check("drop_cycles", valid_cycles, 9);

    // Grid change after cell 2 must not affect the captured frame.
    do_reset();
    cell_ready = 1'b1;
    start_frame(G_DIAG);
    repeat (3) @(posedge clk);
    #1;
    grid_in = '1;
    wait_idle("gchg");
    check("gchg_frames", frame_count, 1);

    // Reset mid-frame after cell 4, then a fresh frame from (0,0).
    do_reset();
    cell_ready = 1'b1;
    start_frame(G_VBLINK);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("mrst_valid",  cell_valid, 0);
    check("mrst_busy",   busy, 0);
    check("mrst_frames", frame_count, 0);
    check("mrst_drops",  drop_count, 0);
    check("mrst_pos",    {cell_row, cell_col}, 0);
    start_frame(G_HBLINK);
    wait_idle("mrst");
    check("mrst_cycles", valid_cycles, 9);
    check("mrst_new_frames", frame_count, 1);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gol_grid_streamer.md
Name: gol_grid_streamer

Overview:
Reader side of the gol grid interface. It snapshots the parallel ROWSxCOLS grid that gol drives each generation and streams the cells out one per handshake, in row-major order, with row/column indices and framing markers. It sits between gol's out bus and a display or logging sink, replacing bench-side parallel display with a hardware serial path.

Parameters:
ROWS, 3, grid rows (>=1)
COLS, 3, grid columns (>=1)
CNT_W, 8, width of frame_count and drop_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
grid_in  input  [ROWS-1:0][COLS-1:0]  live grid from gol out; grid_in[r][c] is the cell at row r, column c
snap  input  1  capture request, sampled each edge
busy  output  1  high while a frame is held or streaming
cell_valid  output  1  cell_* fields valid
cell_ready  input  1  sink accepts the current cell
cell_data  output  1  cell value
cell_row  output  RW  row index, RW = max(1,$clog2(ROWS))
cell_col  output  CW  column index, CW = max(1,$clog2(COLS))
sol  output  1  first cell of a row (col==0)
eol  output  1  last cell of a row (col==COLS-1)
eof  output  1  last cell of the frame (row==ROWS-1, col==COLS-1)
frame_count  output  CNT_W  completed frames, wraps
drop_count  output  CNT_W  ignored snap requests, saturates at all-ones

Behaviour:
- Clock is clk; reset is synchronous, active-low on rst_n. Reset affects only the rising edge of clk.
- Reset values: busy=0, cell_valid=0, cell_data=0, cell_row=0, cell_col=0, sol/eol/eof=0, frame_count=0, drop_count=0, snapshot=0, state=IDLE.
- States: IDLE and STREAM.
- IDLE, snap=1 at edge N:
  - grid_in is copied into the snapshot register at edge N.
  - Cursor is set to (0,0); state moves to STREAM.
  - cell_valid and busy are high from edge N. Latency is 1 edge: the first cell is presented in the cycle after the sampling edge.
- STREAM:
  - cell_data = snapshot[cell_row][cell_col].
  - sol, eol and eof decode from the cursor and are qualified by cell_valid; all are 0 when cell_valid=0.
  - A transfer occurs on any edge where cell_valid and cell_ready are both 1.
  - On a transfer with the cursor not at the end, col increments. When col==COLS-1, col wraps to 0 and row increments.
  - While cell_valid=1 and cell_ready=0, every cell_* output, sol, eol and eof hold stable. cell_valid never drops without a transfer, except on reset.
- Final transfer (eof handshake):
  - frame_count increments, wrapping modulo 2^CNT_W.
  - If snap=0 on the same edge, state returns to IDLE and cell_valid and busy go low.
  - If snap=1 on the same edge, grid_in is recaptured, the cursor goes to (0,0), and the block stays in STREAM with cell_valid continuously high (back-to-back frames, no bubble).
- snap=1 in STREAM on any edge other than the eof handshake: the request is ignored, the snapshot is unchanged, and drop_count increments, saturating at all-ones.
- grid_in changing during STREAM has no effect on the frame being streamed.
- Reset mid-frame: the frame is aborted, all outputs take their reset values at that edge, and no partial frame is counted.
- ROWS=1 or COLS=1: index widths clamp to 1 bit; sol and eol may be high on the same cell.

Decomposition:
- Package gol_pkg holds:
  - GOL_ROWS=3 and GOL_COLS=3 defaults, shared with gol and the benches.
  - The stream_state_t enum {IDLE, STREAM}.
  - An idx_w(n) function returning max(1,$clog2(n)).
- Sub-module gol_cell_cursor:
  - Row/column counter with load-zero, advance, and wrap-at-(ROWS-1,COLS-1).
  - Outputs row, col, at_sol, at_eol and at_eof.
  - The streamer instantiates one cursor.

Test Plan:
- Blinker frame, ROWS=COLS=3, grid_in with column 1 set (rows 0-2 = 010,010,010), snap pulse, cell_ready=1 -> cell_valid high 9 consecutive cycles; cell_data sequence 0,1,0,0,1,0,0,1,0; sol on cells 0,3,6; eol on cells 2,5,8; eof on cell 8 only; then busy=0 and frame_count=1.
- Backpressure: same frame, cell_ready low for 3 cycles while cell 4 is presented -> cell_row=1, cell_col=1, cell_data=1 held stable for 4 cycles; total stream takes 12 cycles.
- Back-to-back: snap asserted on the eof handshake edge with grid_in=horizontal blinker (000,111,000) -> no valid bubble; second frame streams 0,0,0,1,1,1,0,0,0; frame_count=2.
- Drop: snap pulses on 2 edges mid-stream -> drop_count=2 and the current frame data is unchanged.
- Grid change mid-stream: grid_in flipped to all-ones after cell 2 -> remaining cells still match the captured snapshot.
- Reset mid-frame: rst_n=0 for one edge after cell 4 -> cell_valid=0, frame_count=0, drop_count=0, busy=0; a new snap streams from (0,0).
